// File: rtl/mem_arbiter_rr.sv
`default_nettype none
// ============================================================================
// mem_arbiter_rr : N-port cache-to-adapter arbiter, fixed-priority or
//                  round-robin, with a latched command toward memory.
// Revision       : 1.0 - initial release
// ============================================================================
module mem_arbiter_rr #(
  parameter int NUM_PORTS  = 2,
  parameter int LINE_W     = 256,
  parameter int ADDR_W     = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          req_read,
  input  logic [NUM_PORTS-1:0]          req_write,
  input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
  input  logic [NUM_PORTS*LINE_W-1:0]   req_wdata,
  output logic [NUM_PORTS-1:0]          req_resp,
  output logic [LINE_W-1:0]             req_rdata,
  output logic                          mem_read,
  output logic                          mem_write,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [LINE_W-1:0]             mem_wdata,
  input  logic                          mem_resp,
  input  logic [LINE_W-1:0]             mem_rdata,
  output logic                          grant_valid,
  output logic [$clog2(NUM_PORTS)-1:0]  grant_id
);

  localparam int ID_W = $clog2(NUM_PORTS);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t               r_state;
  logic                 r_mem_read;
  logic                 r_mem_write;
  logic                 r_grant_valid;
  logic [ADDR_W-1:0]    r_mem_addr;
  logic [LINE_W-1:0]    r_mem_wdata;
  logic [ID_W-1:0]      r_grant_id;
  logic [ID_W-1:0]      r_rr_ptr;

  logic [NUM_PORTS-1:0] w_active;
  logic [NUM_PORTS-1:0] w_rot;
  logic [ID_W-1:0]      w_win;
  logic [ID_W-1:0]      w_next_ptr;
  logic [ADDR_W-1:0]    w_addr  [NUM_PORTS];
  logic [LINE_W-1:0]    w_wdata [NUM_PORTS];

  assign w_active = req_read | req_write;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
    assign w_addr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
    assign w_wdata[gi] = req_wdata[gi*LINE_W +: LINE_W];
  end

  // Round-robin: rotate the active mask so bit 0 is rr_ptr, then take the
  // lowest set bit; fixed priority takes the highest active index.
  always_comb begin
    w_rot = NUM_PORTS'({w_active, w_active} >> r_rr_ptr);
    w_win = '0;
    if (FIXED_PRIO != 0) begin
      for (int i = 0; i < NUM_PORTS; i++)
        if (w_active[i]) w_win = ID_W'(i);
    end else begin
      for (int k = NUM_PORTS - 1; k >= 0; k--)
        if (w_rot[k]) w_win = ID_W'((int'(r_rr_ptr) + k) % NUM_PORTS);
    end
  end

  assign w_next_ptr = (r_grant_id == ID_W'(NUM_PORTS - 1)) ? '0 : r_grant_id + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_rr_ptr      <= '0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_grant_valid <= 1'b0;
      r_grant_id    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|w_active) begin
            r_state       <= S_BUSY;
            r_grant_id    <= w_win;
            r_grant_valid <= 1'b1;
            r_mem_addr    <= w_addr[w_win];
            r_mem_wdata   <= w_wdata[w_win];
            r_mem_write   <= req_write[w_win];
            r_mem_read    <= req_read[w_win] & ~req_write[w_win];
          end
        end
        S_BUSY: begin
          // Address and write data stay latched after completion.
          if (mem_resp) begin
            r_state       <= S_IDLE;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_grant_valid <= 1'b0;
            r_rr_ptr      <= w_next_ptr;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    req_resp = '0;
    if (r_state == S_BUSY && mem_resp) req_resp[r_grant_id] = 1'b1;
  end

  assign req_rdata   = mem_rdata;
  assign mem_read    = r_mem_read;
  assign mem_write   = r_mem_write;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign grant_valid = r_grant_valid;
  assign grant_id    = r_grant_id;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter_rr.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter_rr : scoreboard bench; u_fp = 2 ports fixed priority,
//                     u_rr = 4 ports round-robin.
// Revision          : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter_rr;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [1:0]   a_req_read, a_req_write, a_req_resp;
  logic [63:0]  a_req_addr;
  logic [511:0] a_req_wdata;
  logic [255:0] a_req_rdata, a_mem_wdata, a_mem_rdata;
  logic         a_mem_read, a_mem_write, a_mem_resp, a_grant_valid;
  logic [31:0]  a_mem_addr;
  logic [0:0]   a_grant_id;

  logic [3:0]    b_req_read, b_req_write, b_req_resp;
  logic [127:0]  b_req_addr;
  logic [1023:0] b_req_wdata;
  logic [255:0]  b_req_rdata, b_mem_wdata, b_mem_rdata;
  logic          b_mem_read, b_mem_write, b_mem_resp, b_grant_valid;
  logic [31:0]   b_mem_addr;
  logic [1:0]    b_grant_id;

  mem_arbiter_rr #(.NUM_PORTS(2), .LINE_W(256), .ADDR_W(32), .FIXED_PRIO(1)) u_fp (
    .clk(clk), .rst(rst), .req_read(a_req_read), .req_write(a_req_write),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_resp(a_req_resp),
    .req_rdata(a_req_rdata), .mem_read(a_mem_read), .mem_write(a_mem_write),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_resp(a_mem_resp),
    .mem_rdata(a_mem_rdata), .grant_valid(a_grant_valid), .grant_id(a_grant_id));

  mem_arbiter_rr #(.NUM_PORTS(4), .LINE_W(256), .ADDR_W(32), .FIXED_PRIO(0)) u_rr (
    .clk(clk), .rst(rst), .req_read(b_req_read), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_resp(b_req_resp),
    .req_rdata(b_req_rdata), .mem_read(b_mem_read), .mem_write(b_mem_write),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_resp(b_mem_resp),
    .mem_rdata(b_mem_rdata), .grant_valid(b_grant_valid), .grant_id(b_grant_id));

  typedef struct {
    int           id;
    logic         rd;
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] wdata;
  } grant_t;
  typedef struct {
    logic [3:0]   resp;
    logic [255:0] rdata;
  } resp_t;

  grant_t qa_g[$], qb_g[$];
  resp_t  qa_r[$], qb_r[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic ok, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  function automatic logic [319:0] gpack(input int id, input logic rd, input logic wr,
                                         input logic [31:0] addr, input logic [255:0] wd);
    return {22'b0, 8'(id), rd, wr, addr, wd};
  endfunction

  task automatic push_g(input bit to_b, input int id, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [255:0] wd);
    grant_t g;
    g = '{id, rd, wr, addr, wd};
    if (to_b) qb_g.push_back(g); else qa_g.push_back(g);
  endtask

  task automatic push_r(input bit to_b, input logic [3:0] resp, input logic [255:0] rd);
    resp_t r;
    r = '{resp, rd};
    if (to_b) qb_r.push_back(r); else qa_r.push_back(r);
  endtask

  // Scoreboard monitors: a grant record is consumed on each rising
  // grant_valid, a response record on each non-zero req_resp.
  logic a_gv_q = 1'b0;
  logic b_gv_q = 1'b0;
  always @(negedge clk) begin
    grant_t g;
    resp_t  r;
    logic [319:0] act, exp;
    if (a_grant_valid && !a_gv_q) begin
      act = gpack(int'(a_grant_id), a_mem_read, a_mem_write, a_mem_addr, a_mem_wdata);
      if (qa_g.size() == 0) chk("fp_grant_unexpected", 1'b0, act, '0);
      else begin
        g = qa_g.pop_front();
        exp = gpack(g.id, g.rd, g.wr, g.addr, g.wdata);
        chk("fp_grant", act == exp, act, exp);
      end
    end
    a_gv_q = a_grant_valid;
    if (a_req_resp != 2'b00) begin
      act = {62'b0, 2'b00, a_req_resp, a_req_rdata};
      if (qa_r.size() == 0) chk("fp_resp_unexpected", 1'b0, act, '0);
      else begin
        r = qa_r.pop_front();
        exp = {60'b0, r.resp, r.rdata};
        chk("fp_resp", act == exp, act, exp);
      end
    end
  end

  always @(negedge clk) begin
    grant_t g;
    resp_t  r;
    logic [319:0] act, exp;
    if (b_grant_valid && !b_gv_q) begin
      act = gpack(int'(b_grant_id), b_mem_read, b_mem_write, b_mem_addr, b_mem_wdata);
      if (qb_g.size() == 0) chk("rr_grant_unexpected", 1'b0, act, '0);
      else begin
        g = qb_g.pop_front();
        exp = gpack(g.id, g.rd, g.wr, g.addr, g.wdata);
        chk("rr_grant", act == exp, act, exp);
      end
    end
    b_gv_q = b_grant_valid;
    if (b_req_resp != 4'b0000) begin
      act = {60'b0, b_req_resp, b_req_rdata};
      if (qb_r.size() == 0) chk("rr_resp_unexpected", 1'b0, act, '0);
      else begin
        r = qb_r.pop_front();
        exp = {60'b0, r.resp, r.rdata};
        chk("rr_resp", act == exp, act, exp);
      end
    end
  end

  task automatic a_serve(input int dly, input logic [255:0] rd, input logic [1:0] drop);
    repeat (dly) @(posedge clk);
    #1 a_mem_rdata = rd; a_mem_resp = 1'b1;
    @(posedge clk);
    #1 a_mem_resp = 1'b0;
    a_req_read  = a_req_read & ~drop;
    a_req_write = a_req_write & ~drop;
  endtask

  task automatic b_serve(input int dly, input logic [255:0] rd, input logic [3:0] drop);
    repeat (dly) @(posedge clk);
    #1 b_mem_rdata = rd; b_mem_resp = 1'b1;
    @(posedge clk);
    #1 b_mem_resp = 1'b0;
    b_req_read  = b_req_read & ~drop;
    b_req_write = b_req_write & ~drop;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  initial begin
    logic [31:0]  rr_addr [4];
    logic [255:0] rr_wd   [4];
    int           rr_ids  [6];
    logic [319:0] v;

    rr_addr = '{32'h2000, 32'h2040, 32'h2080, 32'h20C0};
    rr_wd   = '{{32{8'h10}}, {32{8'h21}}, {32{8'h32}}, {32{8'h43}}};
    rr_ids  = '{0, 1, 2, 3, 0, 1};

    rst = 1'b1;
    a_req_read = '0; a_req_write = '0; a_req_addr = '0; a_req_wdata = '0;
    a_mem_resp = 1'b0; a_mem_rdata = '0;
    b_req_read = '0; b_req_write = '0; b_req_addr = '0; b_req_wdata = '0;
    b_mem_resp = 1'b0; b_mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Idle after reset: every output at zero.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      v = 320'({a_mem_read, a_mem_write, a_grant_valid, a_grant_id, a_req_resp, a_mem_addr, a_mem_wdata});
      chk("fp_idle_outputs", v == '0, v, '0);
      v = 320'({b_mem_read, b_mem_write, b_grant_valid, b_grant_id, b_req_resp, b_mem_addr, b_mem_wdata});
      chk("rr_idle_outputs", v == '0, v, '0);
    end

    // Stray adapter response while idle.
    @(posedge clk);
    #1 a_mem_resp = 1'b1; b_mem_resp = 1'b1;
    @(negedge clk);
    chk("stray_resp_idle", {a_req_resp, b_req_resp} == 6'b0, 320'({a_req_resp, b_req_resp}), '0);
    @(posedge clk);
    #1 a_mem_resp = 1'b0; b_mem_resp = 1'b0;
    @(negedge clk);
    chk("stray_no_grant", {a_grant_valid, b_grant_valid} == 2'b0, 320'({a_grant_valid, b_grant_valid}), '0);

    // Single read from port 0.
    @(posedge clk);
    #1 a_req_addr[31:0] = 32'h0000_1000; a_req_read = 2'b01;
    push_g(1'b0, 0, 1'b1, 1'b0, 32'h0000_1000, '0);
    push_r(1'b0, 4'b0001, {32{8'hA5}});
    @(posedge clk);
    @(negedge clk);
    chk("rd_cmd", a_mem_read && a_mem_addr == 32'h1000, 320'({a_mem_read, a_mem_addr}), 320'({1'b1, 32'h1000}));
    a_serve(4, {32{8'hA5}}, 2'b01);
    @(negedge clk);
    chk("rd_done", !a_mem_read && !a_grant_valid, 320'({a_mem_read, a_grant_valid}), '0);

    // Simultaneous port0 read / port1 write: port1 wins, one IDLE cycle, then port0.
    @(posedge clk);
    #1 a_req_addr[31:0] = 32'h100; a_req_addr[63:32] = 32'h200;
    a_req_wdata[511:256] = {32{8'h5A}};
    a_req_read = 2'b01; a_req_write = 2'b10;
    push_g(1'b0, 1, 1'b0, 1'b1, 32'h200, {32{8'h5A}});
    push_g(1'b0, 0, 1'b1, 1'b0, 32'h100, '0);
    push_r(1'b0, 4'b0010, {8{32'h1111_2222}});
    push_r(1'b0, 4'b0001, {8{32'h3333_4444}});
    a_serve(3, {8{32'h1111_2222}}, 2'b10);
    @(negedge clk);
    chk("gap_idle_cycle", !a_grant_valid, 320'(a_grant_valid), '0);
    a_serve(3, {8{32'h3333_4444}}, 2'b01);

    // Hold stability; port1 with read and write both set must issue a write.
    @(posedge clk);
    #1 a_req_addr[63:32] = 32'h300; a_req_wdata[511:256] = {32{8'h3C}};
    a_req_read = 2'b10; a_req_write = 2'b10;
    push_g(1'b0, 1, 1'b0, 1'b1, 32'h300, {32{8'h3C}});
    push_r(1'b0, 4'b0010, {8{32'h0BAD_F00D}});
    @(posedge clk);
    #1 a_req_addr[63:32] = 32'h400; a_req_wdata[511:256] = {32{8'hC3}};
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      v = 320'({a_mem_write, a_mem_read, a_mem_addr, a_mem_wdata});
      chk("hold_cmd", v == 320'({1'b1, 1'b0, 32'h300, {32{8'h3C}}}), v,
          320'({1'b1, 1'b0, 32'h300, {32{8'h3C}}}));
    end
    a_serve(1, {8{32'h0BAD_F00D}}, 2'b10);

    // Reset in the middle of a transaction.
    @(posedge clk);
    #1 a_req_addr[31:0] = 32'h700; a_req_read = 2'b01;
    push_g(1'b0, 0, 1'b1, 1'b0, 32'h700, '0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1; a_req_read = 2'b00;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    v = 320'({a_grant_valid, a_mem_read, a_req_resp, a_mem_addr});
    chk("rst_mid_txn", v == '0, v, '0);
    @(posedge clk);
    #1 a_mem_resp = 1'b1;
    @(negedge clk);
    chk("rst_late_resp", a_req_resp == 2'b00, 320'(a_req_resp), '0);
    @(posedge clk);
    #1 a_mem_resp = 1'b0;

    // Round-robin with all four ports requesting continuously (port2 writes).
    @(posedge clk);
    #1;
    for (int p = 0; p < 4; p++) begin
      b_req_addr[p*32 +: 32]    = rr_addr[p];
      b_req_wdata[p*256 +: 256] = rr_wd[p];
    end
    b_req_read = 4'b1011; b_req_write = 4'b0100;
    for (int k = 0; k < 6; k++) begin
      push_g(1'b1, rr_ids[k], rr_ids[k] != 2, rr_ids[k] == 2, rr_addr[rr_ids[k]], rr_wd[rr_ids[k]]);
      push_r(1'b1, 4'(1 << rr_ids[k]), {8{32'hC0DE_0000 + 32'(k)}});
    end
    for (int k = 0; k < 6; k++)
      b_serve(2, {8{32'hC0DE_0000 + 32'(k)}}, (k == 5) ? 4'hF : 4'h0);
    repeat (3) @(negedge clk);
    chk("rr_done_idle", !b_grant_valid, 320'(b_grant_valid), '0);

    repeat (2) @(negedge clk);
    chk("fp_queues_drained", qa_g.size() == 0 && qa_r.size() == 0,
        320'({qa_g.size(), qa_r.size()}), '0);
    chk("rr_queues_drained", qb_g.size() == 0 && qb_r.size() == 0,
        320'({qb_g.size(), qb_r.size()}), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
